// File: rtl/physics_frame_scheduler_pkg.sv
// Shared types for the physics frame scheduler: FSM states, paddle position
// layout and field helpers reused by physics_core and the renderer.
package physics_frame_scheduler_pkg;

  localparam int POS_W     = 24;
  localparam int POS_X_LSB = 2 * POS_W;
  localparam int POS_Y_LSB = POS_W;
  localparam int POS_Z_LSB = 0;

  // Packed {X,Y,Z}, each a 16.8 fixed-point coordinate.
  typedef logic [3*POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    PUBLISH = 2'd2
  } pfs_state_e;

  function automatic logic [POS_W-1:0] pos_x(input pos_t p);
    return p[POS_X_LSB +: POS_W];
  endfunction

  function automatic logic [POS_W-1:0] pos_y(input pos_t p);
    return p[POS_Y_LSB +: POS_W];
  endfunction

  function automatic logic [POS_W-1:0] pos_z(input pos_t p);
    return p[POS_Z_LSB +: POS_W];
  endfunction

endpackage

// File: rtl/physics_frame_scheduler_if.sv
// Scheduler-facing bus: step/done handshake with physics_core and the
// valid/ready frame hand-off to the renderer.
interface physics_frame_scheduler_if;
  import physics_frame_scheduler_pkg::*;

  pos_t        pc_paddle_1_pos;
  pos_t        pc_paddle_2_pos;
  logic        pc_step;
  logic        pc_done;
  logic        gr_frame_valid;
  logic        gr_frame_ready;
  logic [15:0] gr_frame_id;

  modport master (
    output pc_paddle_1_pos, pc_paddle_2_pos, pc_step, gr_frame_valid, gr_frame_id,
    input  pc_done, gr_frame_ready
  );

  modport slave (
    input  pc_paddle_1_pos, pc_paddle_2_pos, pc_step, gr_frame_valid, gr_frame_id,
    output pc_done, gr_frame_ready
  );

endinterface

// File: rtl/physics_frame_scheduler_stale.sv
// pfs_stale_tracker: counts frame ticks without a paddle sample and flags
// the feed stale once the saturating count reaches STALE_FRAMES.
module pfs_stale_tracker #(
  parameter int STALE_FRAMES = 8
) (
  input  logic aclk,
  input  logic areset,
  input  logic tick,
  input  logic valid,
  output logic stale
);

  localparam int CNT_W = $clog2(STALE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALE_FRAMES);

  logic [CNT_W-1:0] cnt;
  logic             seen;

  // seen remembers a sample since the last tick; a sample coinciding with a
  // tick belongs to that tick's frame, so it does not carry forward.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt  <= '0;
      seen <= 1'b0;
    end else if (valid) begin
      cnt  <= '0;
      seen <= ~tick;
    end else if (tick) begin
      seen <= 1'b0;
      if (!seen && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
    end
  end

  assign stale = (cnt == CNT_MAX);

endmodule

// File: rtl/physics_frame_scheduler.sv
// Frame sequencer: snapshots paddles, steps physics_core once per frame and
// publishes the frame. Define PFS_OVERRUN_COUNT_EN to add overrun_count.
module physics_frame_scheduler
  import physics_frame_scheduler_pkg::*;
#(
  parameter int FRAME_CYCLES = 833333,
  parameter int STEP_TIMEOUT = 65535,
  parameter int STALE_FRAMES = 8
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       enable,
  input  pos_t                       ip_paddle_1_pos,
  input  logic                       ip_paddle_1_valid,
  input  pos_t                       ip_paddle_2_pos,
  input  logic                       ip_paddle_2_valid,
  physics_frame_scheduler_if.master  bus,
  output logic                       stale_1,
  output logic                       stale_2,
  output logic                       step_error
`ifdef PFS_OVERRUN_COUNT_EN
  ,
  output logic [15:0]                overrun_count
`endif
);

  localparam int TICK_W = $clog2(FRAME_CYCLES);
  localparam int TO_W   = $clog2(STEP_TIMEOUT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(STEP_TIMEOUT);

  pfs_state_e        state, state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_inc;
  logic              tick;
  logic              step_start;
  logic              timeout_hit;
  logic              frame_accept;
  logic              tick_drop;

  pos_t        shadow_1, shadow_2;
  pos_t        snap_1, snap_2;
  logic        step_q;
  logic [15:0] frame_id;

  always_ff @(posedge aclk) begin
    if (areset || (tick_cnt == TICK_LAST)) tick_cnt <= '0;
    else                                   tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick       = (tick_cnt == TICK_LAST) && enable;
  assign to_cnt_inc = to_cnt + 1'b1;

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Ticks arriving outside IDLE are dropped rather than queued.
  always_comb begin
    state_nxt    = state;
    step_start   = 1'b0;
    timeout_hit  = 1'b0;
    frame_accept = 1'b0;
    tick_drop    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          step_start = 1'b1;
          state_nxt  = STEP;
        end
      end
      STEP: begin
        tick_drop = tick;
        if (bus.pc_done) begin
          state_nxt = PUBLISH;
        end else if (to_cnt_inc == TO_LIMIT) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      PUBLISH: begin
        tick_drop = tick;
        if (bus.gr_frame_ready) begin
          frame_accept = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      shadow_1   <= '0;
      shadow_2   <= '0;
      snap_1     <= '0;
      snap_2     <= '0;
      step_q     <= 1'b0;
      to_cnt     <= '0;
      step_error <= 1'b0;
      frame_id   <= '0;
    end else begin
      step_q <= step_start;
      if (ip_paddle_1_valid) shadow_1 <= ip_paddle_1_pos;
      if (ip_paddle_2_valid) shadow_2 <= ip_paddle_2_pos;
      // A sample in the tick cycle itself bypasses the shadow register.
      if (step_start) begin
        snap_1 <= ip_paddle_1_valid ? ip_paddle_1_pos : shadow_1;
        snap_2 <= ip_paddle_2_valid ? ip_paddle_2_pos : shadow_2;
        to_cnt <= '0;
      end else if (state == STEP) begin
        to_cnt <= to_cnt_inc;
      end
      if (timeout_hit)  step_error <= 1'b1;
      if (frame_accept) frame_id   <= frame_id + 16'd1;
    end
  end

`ifdef PFS_OVERRUN_COUNT_EN
  always_ff @(posedge aclk) begin
    if (areset)                                 overrun_count <= '0;
    else if (tick_drop && (overrun_count != 16'hFFFF)) overrun_count <= overrun_count + 16'd1;
  end
`else
  logic unused_tick_drop;
  assign unused_tick_drop = tick_drop;
`endif

  assign bus.pc_paddle_1_pos = snap_1;
  assign bus.pc_paddle_2_pos = snap_2;
  assign bus.pc_step         = step_q;
  assign bus.gr_frame_valid  = (state == PUBLISH);
  assign bus.gr_frame_id     = frame_id;

  pfs_stale_tracker #(.STALE_FRAMES(STALE_FRAMES)) u_stale_1 (
    .aclk   (aclk),
    .areset (areset),
    .tick   (tick),
    .valid  (ip_paddle_1_valid),
    .stale  (stale_1)
  );

  pfs_stale_tracker #(.STALE_FRAMES(STALE_FRAMES)) u_stale_2 (
    .aclk   (aclk),
    .areset (areset),
    .tick   (tick),
    .valid  (ip_paddle_2_valid),
    .stale  (stale_2)
  );

endmodule

// File: doc/physics_frame_scheduler.md
Name: physics_frame_scheduler

Overview:
- Sequences physics_core once per video frame.
- Arbitrates the two asynchronous paddle-sample streams into a frame-coherent snapshot, then starts one physics step.
- Waits for the step to complete, then hands the frame to the graphics renderer over a valid/ready handshake.
- Sits between the two input-processor paddle feeds, physics_core and the renderer.

Parameters:
- FRAME_CYCLES, 833333: aclk cycles per frame tick (60 Hz at 50 MHz); minimum 4.
- STEP_TIMEOUT, 65535: maximum cycles to wait for pc_done before aborting the step.
- STALE_FRAMES, 8: consecutive frames with no valid sample before a paddle is flagged stale.
- POS_W, 24: width of one 16.8 fixed-point coordinate.

Ports:
- aclk  in  1  system clock, rising edge.
- areset  in  1  synchronous reset, active-high.
- enable  in  1  frame ticks are honoured only while high.
- ip_paddle_1_pos  in  3*POS_W  packed {X,Y,Z}, player 1.
- ip_paddle_1_valid  in  1  one-cycle sample strobe, player 1.
- ip_paddle_2_pos  in  3*POS_W  packed {X,Y,Z}, player 2.
- ip_paddle_2_valid  in  1  one-cycle sample strobe, player 2.
- pc_paddle_1_pos  out  3*POS_W  frozen snapshot to physics_core.
- pc_paddle_2_pos  out  3*POS_W  frozen snapshot to physics_core.
- pc_step  out  1  one-cycle start pulse to physics_core.
- pc_done  in  1  one-cycle completion pulse from physics_core.
- gr_frame_valid  out  1  frame results ready for the renderer.
- gr_frame_ready  in  1  renderer accepts the frame.
- gr_frame_id  out  16  frame sequence number.
- stale_1, stale_2  out  1  paddle feed stale flags.
- step_error  out  1  sticky timeout flag.

Behaviour:
- Reset: clock domain aclk; areset is synchronous, active-high. While areset is high:
  - all outputs are 0;
  - tick counter, timeout counter and stale counters are 0;
  - shadow registers are 0;
  - FSM is IDLE.
  - Reset asserted mid-step or mid-publish aborts immediately; no pc_step or gr_frame_valid appears in the following cycle.
- Tick counter:
  - counts 0..FRAME_CYCLES-1 and wraps to 0;
  - tick is true combinationally when count == FRAME_CYCLES-1 and enable is high;
  - the counter runs regardless of enable.
- Shadow capture:
  - ip_paddle_N_valid loads ip_paddle_N_pos into shadow_N at the next edge;
  - samples between ticks overwrite each other, so the last sample wins.
- FSM states: IDLE, STEP, PUBLISH.
  - IDLE -> STEP on tick. At that same edge:
    - pc_paddle_N_pos loads shadow_N, bypassed by ip_paddle_N_pos if ip_paddle_N_valid is high in the tick cycle;
    - pc_step is registered high for exactly one cycle;
    - the timeout counter clears.
  - pc_paddle_N_pos is stable from STEP entry until the next STEP entry.
  - STEP -> PUBLISH on pc_done. pc_done arriving in the pc_step cycle is accepted; pc_done seen in IDLE or PUBLISH is ignored.
  - STEP -> IDLE when the timeout counter reaches STEP_TIMEOUT without pc_done. This sets step_error, which stays high until reset.
  - In PUBLISH, gr_frame_valid is high and gr_frame_id is stable.
  - PUBLISH -> IDLE on gr_frame_valid && gr_frame_ready. gr_frame_id increments (mod 2^16) at that edge.
  - Latency: tick cycle T -> pc_step high in T+1 -> pc_done at D -> gr_frame_valid high in D+1.
- Overrun:
  - a tick in STEP or PUBLISH is dropped, not queued;
  - the next step waits for the following tick.
- Stale flags:
  - stale counter N increments on each tick with no ip_paddle_N_valid since the previous tick, saturating at STALE_FRAMES;
  - stale_N = (counter == STALE_FRAMES);
  - any ip_paddle_N_valid clears counter and flag at the next edge.
  - If valid and tick coincide, the clear wins.

Optional Feature:
- Macro PFS_OVERRUN_COUNT_EN.
- When defined:
  - adds output overrun_count, 16 bits;
  - increments on each dropped tick;
  - saturates at 16'hFFFF;
  - reset to 0 by areset.
- When undefined: the port is absent and dropped ticks are silent.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE/STEP/PUBLISH);
  - POS_W;
  - packed position typedef and its X/Y/Z slice offsets, reused by physics_core and the renderer.
- One natural sub-module: pfs_stale_tracker, instantiated once per paddle. It holds the saturating counter and flag, with inputs tick and valid.

Test Plan:
- FRAME_CYCLES=100, enable=1, pc_done returned 10 cycles after pc_step -> pc_step pulses at cycles 100, 200, ... after reset release; gr_frame_valid rises 11 cycles after each pc_step; gr_frame_id counts 0, 1, 2.
- Paddle 1 valid with X=24'h001200, then X=24'h003400 before the tick -> pc_paddle_1_pos X=24'h003400. Valid with X=24'h005600 in the tick cycle itself -> X=24'h005600 (bypass).
- gr_frame_ready held low for 250 cycles -> gr_frame_valid and gr_frame_id stay stable; two ticks are dropped; overrun_count=2 with PFS_OVERRUN_COUNT_EN defined.
- pc_done never returned, STEP_TIMEOUT=20 -> FSM returns to IDLE 20 cycles after pc_step; step_error=1 and remains 1; the next tick issues pc_step again.
- Paddle 2 silent for 8 ticks with STALE_FRAMES=8 -> stale_2=1 after the 8th tick. One valid pulse -> stale_2=0 the next cycle.
- areset asserted one cycle after pc_step -> all outputs 0 the next cycle; a later pc_done is ignored; the first step after release occurs 100 cycles later.
